// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED-protected RAM.
// Holds the check-bit / codeword width calculations, the position helpers
// used to build the extended Hamming code, the scrub state enum, and a
// saturating counter helper.
package ecc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CHK  = 2'd2,
    S_WB   = 2'd3
  } scrub_state_t;

  // Smallest p with 2^p >= w + p + 1 (w is 4..32, so p never exceeds 6).
  function automatic int calc_p(input int w);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--) begin
      if ((1 << k) >= w + k + 1) p = k;
    end
    return p;
  endfunction

  // Codeword width: data + Hamming check bits + overall parity at position 0.
  function automatic int calc_cw(input int w);
    return w + calc_p(w) + 1;
  endfunction

  function automatic bit is_pow2(input int j);
    return (j != 0) && ((j & (j - 1)) == 0);
  endfunction

  // Data bit index stored at codeword position j (j must not be 0 or a power of 2).
  function automatic int data_idx(input int j);
    int n;
    n = 0;
    for (int k = 1; k < j; k++) begin
      if (!is_pow2(k)) n++;
    end
    return n;
  endfunction

  // Positions covered by check bit i: every position whose index has bit i set.
  function automatic logic [63:0] chk_mask(input int i);
    logic [63:0] m;
    m = '0;
    for (int j = 1; j < 64; j++) m[j] = ((j >> i) & 1) == 1;
    return m;
  endfunction

  // Add up to two events to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic a, input logic b);
    logic [8:0] s;
    s = {1'b0, c} + {8'd0, a} + {8'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/ecc_ram_if.sv
// ecc_ram_if: host-side bundle of the SECDED RAM.
// master = host/bench, slave = ecc_ram.
//   addr, data_in, req, rw, inj_mask : host access request
//   scrub                            : one-cycle scrub start request
//   oe                               : output enable for data_out
//   data_out, valid, sec, ded        : read result
//   busy, corr_cnt, uncorr_cnt       : scrub status and error counters
//   dbg_state                        : scrub FSM state
//
// Handshake: req is sampled on every rising edge and is accepted only while
// busy=0 (no back-pressure otherwise; a request during busy is dropped).
// An accepted read at edge N produces valid=1 for exactly the one cycle
// following edge N+1; data_out/sec/ded then hold until the next valid pulse.
// Writes produce no response.
interface ecc_ram_if #(
  parameter int L = 16,
  parameter int W = 4
);
  import ecc_pkg::*;

  localparam int CW = calc_cw(W);
  localparam int AW = (L > 1) ? $clog2(L) : 1;

  logic [AW-1:0] addr;
  logic [W-1:0]  data_in;
  logic          req;
  logic          rw;
  logic [CW-1:0] inj_mask;
  logic          scrub;
  logic          oe;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          sec;
  logic          ded;
  logic          busy;
  logic [7:0]    corr_cnt;
  logic [7:0]    uncorr_cnt;
  scrub_state_t  dbg_state;

  modport master (
    output addr, data_in, req, rw, inj_mask, scrub, oe,
    input  data_out, valid, sec, ded, busy, corr_cnt, uncorr_cnt, dbg_state
  );

  modport slave (
    input  addr, data_in, req, rw, inj_mask, scrub, oe,
    output data_out, valid, sec, ded, busy, corr_cnt, uncorr_cnt, dbg_state
  );

endinterface

// File: rtl/hamming_secded.sv
// hamming_secded: combinational extended-Hamming SECDED encoder + decoder.
//   data     in  W   data to encode
//   cw_enc   out CW  codeword of data (check bits at power-of-2 positions,
//                    data LSB-first in the remaining positions, even
//                    overall parity at position 0)
//   cw_in    in  CW  codeword to decode
//   data_dec out W   decoded data (corrected on sec, raw on ded)
//   sec      out 1   single error corrected (overall parity wrong)
//   ded      out 1   double error detected (parity ok, syndrome nonzero)
module hamming_secded
  import ecc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [calc_cw(W)-1:0] cw_in,
  input  logic [W-1:0]          data,
  output logic [calc_cw(W)-1:0] cw_enc,
  output logic [W-1:0]          data_dec,
  output logic                  sec,
  output logic                  ded
);

  localparam int P  = calc_p(W);
  localparam int CW = calc_cw(W);

  logic [CW-1:0] placed;  // data bits at their positions, zeros elsewhere
  logic [CW-1:0] body;    // placed plus check bits, position 0 still zero
  logic [P-1:0]  syn;
  logic          parity_bad;
  logic [CW-1:0] flip;
  logic [CW-1:0] fixed;

  for (genvar j = 0; j < CW; j++) begin : g_pos
    if (j == 0) begin : g_par
      assign placed[j] = 1'b0;
      assign body[j]   = 1'b0;
    end else if (is_pow2(j)) begin : g_chk
      localparam logic [63:0]   CM  = chk_mask($clog2(j));
      localparam logic [CW-1:0] CMW = CM[CW-1:0];
      assign placed[j] = 1'b0;
      assign body[j]   = ^(placed & CMW);
    end else begin : g_dat
      localparam int DI = data_idx(j);
      assign placed[j]    = data[DI];
      assign body[j]      = placed[j];
      assign data_dec[DI] = fixed[j];
    end
  end

  assign cw_enc = {body[CW-1:1], ^body};

  for (genvar i = 0; i < P; i++) begin : g_syn
    localparam logic [63:0]   SM  = chk_mask(i);
    localparam logic [CW-1:0] SMW = SM[CW-1:0];
    assign syn[i] = ^(cw_in & SMW);
  end

  assign parity_bad = ^cw_in;

  // Odd overall parity means one flipped bit; the syndrome names it, with
  // syndrome 0 pointing at the parity bit itself.
  always_comb begin
    flip = '0;
    for (int j = 0; j < CW; j++) begin
      if (int'(syn) == j) flip[j] = parity_bad;
    end
  end

  assign fixed = cw_in ^ flip;
  assign sec   = parity_bad;
  assign ded   = !parity_bad && (syn != '0);

endmodule

// File: rtl/ecc_ram.sv
// ecc_ram: L x W RAM stored as SECDED codewords, with a background scrubber.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset (memory array is not reset)
//   bus    ecc_ram_if.slave: host access, scrub request, read result,
//          busy flag, saturating error counters, scrub FSM state
// Host reads are a two-stage pipeline: array read, then decode into the
// held output registers. The scrubber walks every address: read, check,
// and rewrite only words that held a correctable error.
module ecc_ram
  import ecc_pkg::*;
#(
  parameter int L = 16,
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       reset,
  ecc_ram_if.slave   bus
);

  localparam int            CW   = calc_cw(W);
  localparam int            AW   = (L > 1) ? $clog2(L) : 1;
  localparam logic [AW-1:0] LAST = AW'(L - 1);

  logic [CW-1:0] mem [L];

  scrub_state_t  state_q, state_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [CW-1:0] scw_q;
  logic [W-1:0]  wb_data_q;
  logic          wb_wr, chk_en, busy;

  logic          host_rd, host_wr;
  logic [CW-1:0] host_enc, rd_cw_q, wb_enc;
  logic [W-1:0]  host_dec, scrub_dec, data_q;
  logic          host_sec, host_ded, scrub_sec, scrub_ded;
  logic          rd_v_q, valid_q, sec_q, ded_q;
  logic [7:0]    corr_q, uncorr_q;

  assign busy    = (state_q != S_IDLE);
  assign host_rd = bus.req && !bus.rw && !busy;
  assign host_wr = bus.req &&  bus.rw && !busy;

  hamming_secded #(.W(W)) u_host (
    .cw_in    (rd_cw_q),
    .data     (bus.data_in),
    .cw_enc   (host_enc),
    .data_dec (host_dec),
    .sec      (host_sec),
    .ded      (host_ded)
  );

  // Decodes the scrubbed word and re-encodes the corrected copy for write-back.
  hamming_secded #(.W(W)) u_scrub (
    .cw_in    (scw_q),
    .data     (wb_data_q),
    .cw_enc   (wb_enc),
    .data_dec (scrub_dec),
    .sec      (scrub_sec),
    .ded      (scrub_ded)
  );

  always_comb begin
    state_d = state_q;
    saddr_d = saddr_q;
    wb_wr   = 1'b0;
    chk_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A host request in the same cycle wins over the scrub request.
        if (bus.scrub && !bus.req) begin
          state_d = S_RD;
          saddr_d = '0;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        chk_en = 1'b1;
        if (scrub_sec) begin
          state_d = S_WB;
        end else if (saddr_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          saddr_d = saddr_q + AW'(1);
          state_d = S_RD;
        end
      end
      S_WB: begin
        wb_wr = 1'b1;
        if (saddr_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          saddr_d = saddr_q + AW'(1);
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      saddr_q <= saddr_d;
    end
  end

  // Array and datapath registers; host writes and write-backs never coincide
  // because host access is only accepted while the scrubber is idle.
  always_ff @(posedge clk) begin
    if (host_wr)    mem[bus.addr] <= host_enc ^ bus.inj_mask;
    else if (wb_wr) mem[saddr_q]  <= wb_enc;
    if (host_rd)           rd_cw_q   <= mem[bus.addr];
    if (state_q == S_RD)   scw_q     <= mem[saddr_q];
    if (chk_en)            wb_data_q <= scrub_dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      rd_v_q  <= host_rd;
      valid_q <= rd_v_q;
      if (rd_v_q) begin
        data_q <= host_dec;
        sec_q  <= host_sec;
        ded_q  <= host_ded;
      end
      corr_q   <= sat_add(corr_q,   rd_v_q && host_sec, chk_en && scrub_sec);
      uncorr_q <= sat_add(uncorr_q, rd_v_q && host_ded, chk_en && scrub_ded);
    end
  end

  assign bus.data_out   = bus.oe ? data_q : {W{1'bz}};
  assign bus.valid      = valid_q;
  assign bus.sec        = sec_q;
  assign bus.ded        = ded_q;
  assign bus.busy       = busy;
  assign bus.corr_cnt   = corr_q;
  assign bus.uncorr_cnt = uncorr_q;
  assign bus.dbg_state  = state_q;

endmodule
